// File: rtl/mac_unit.sv
// Iterative multiply/accumulate unit (MULT/MULTU/MADD/MADDU/MSUB/MSUBU), STEP multiplier bits per cycle.
// Define MAC_EARLY_TERM_EN to leave BUSY as soon as the remaining multiplier bits are all zero.
module mac_unit #(
   parameter int WIDTH = 32,
   parameter int STEP  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 annul_i,
   input  logic [2:0]           op_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic [2*WIDTH-1:0]   acc_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o,
   output logic                 busy_o
);

   localparam int N  = WIDTH / STEP;
   localparam int CW = $clog2(N + 1);
   localparam int PW = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  mcand_q, mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [PW-1:0]     partial_q, partial_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [PW-1:0]     result_q, result_d;
   logic [CW-1:0]     count_q, count_d;
   logic [1:0]        mode_q, mode_d;
   logic              sign_q, sign_d;

   logic [WIDTH+STEP-1:0] digit_prod;
   logic [PW-1:0]         step_pp;
   logic [PW-1:0]         fixed_p;
   logic                  last_step;

   // Operands are multiplied as magnitudes; the sign is restored in FIX.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
      return (is_signed && v[WIDTH-1]) ? -v : v;
   endfunction

   always_comb begin
      digit_prod = {{STEP{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, mplier_q[STEP-1:0]};
      step_pp    = PW'(digit_prod) << (count_q * STEP);
      fixed_p    = sign_q ? -partial_q : partial_q;
`ifdef MAC_EARLY_TERM_EN
      last_step  = (count_q == CW'(N - 1)) || ((mplier_q >> STEP) == '0);
`else
      last_step  = (count_q == CW'(N - 1));
`endif
   end

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      partial_d = partial_q;
      acc_d     = acc_q;
      result_d  = result_q;
      count_d   = count_q;
      mode_d    = mode_q;
      sign_d    = sign_q;
      if (annul_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_d   = BUSY;
                  mcand_d   = magnitude(opdata1_i, op_i[0]);
                  mplier_d  = magnitude(opdata2_i, op_i[0]);
                  acc_d     = acc_i;
                  mode_d    = op_i[2:1];
                  sign_d    = op_i[0] & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                  partial_d = '0;
                  count_d   = '0;
               end
            end
            BUSY: begin
               partial_d = partial_q + step_pp;
               mplier_d  = mplier_q >> STEP;
               count_d   = count_q + CW'(1);
               if (last_step) state_d = FIX;
            end
            FIX: begin
               unique case (mode_q)
                  2'b01:   result_d = acc_q + fixed_p;
                  2'b10:   result_d = acc_q - fixed_p;
                  default: result_d = fixed_p;
               endcase
               state_d = DONE;
            end
            DONE: begin
               if (!start_i) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         partial_q <= '0;
         acc_q     <= '0;
         result_q  <= '0;
         count_q   <= '0;
         mode_q    <= '0;
         sign_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         partial_q <= partial_d;
         acc_q     <= acc_d;
         result_q  <= result_d;
         count_q   <= count_d;
         mode_q    <= mode_d;
         sign_q    <= sign_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = (state_q == DONE);
   assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_mac_unit.sv
// Self-checking bench for mac_unit (WIDTH=32, STEP=2): directed cases plus randomized ops against an arithmetic model.
module tb_mac_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic        annul_i;
   logic [2:0]  op_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic [63:0] acc_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        busy_o;

   int n_cmp = 0;
   int n_err = 0;

   mac_unit #(.WIDTH(32), .STEP(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start_i),
      .annul_i   (annul_i),
      .op_i      (op_i),
      .opdata1_i (opdata1_i),
      .opdata2_i (opdata2_i),
      .acc_i     (acc_i),
      .result_o  (result_o),
      .ready_o   (ready_o),
      .busy_o    (busy_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Full-width product of the two operands, then accumulate, all modulo 2^64.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] acc);
      logic [63:0] p;
      longint sa, sb;
      if (op[0]) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         p  = 64'(sa * sb);
      end else begin
         p = {32'b0, a} * {32'b0, b};
      end
      case (op[2:1])
         2'b01:   return acc + p;
         2'b10:   return acc - p;
         default: return p;
      endcase
   endfunction

   // Edges from capture until ready_o is high.
   function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
`ifdef MAC_EARLY_TERM_EN
      logic [31:0] mag;
      int msb;
      mag = (op[0] && b[31]) ? -b : b;
      msb = -1;
      for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
      if (msb < 0) return 2;
      return (msb / 2) + 2;
`else
      return 17;
`endif
   endfunction

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 6))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Called #1 after a rising edge with the DUT idle; returns in the same phase, DUT idle.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] acc,
                         input logic [63:0] exp, input int hold);
      int cyc;
      op_i = op; opdata1_i = a; opdata2_i = b; acc_i = acc; start_i = 1'b1;
      @(posedge clk); #1;
      check({tag, "_busy"}, 64'(busy_o), 64'd1);
      op_i = 3'($urandom); opdata1_i = $urandom; opdata2_i = $urandom; acc_i = {$urandom, $urandom};
      cyc = 0;
      while (!ready_o && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_lat"}, 64'(cyc), 64'(exp_lat(op, b)));
      check({tag, "_res"}, result_o, exp);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
         check({tag, "_hold_res"}, result_o, exp);
      end
      start_i = 1'b0;
      @(posedge clk); #1;
      check({tag, "_rdy_fall"}, 64'(ready_o), 64'd0);
      check({tag, "_idle"}, 64'(busy_o), 64'd0);
   endtask

   initial begin
      logic [63:0] prev;
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [63:0] acc;

      rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; op_i = '0;
      opdata1_i = '0; opdata2_i = '0; acc_i = '0;
      #3;
      check("rst_result", result_o, 64'd0);
      check("rst_ready", 64'(ready_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      run_op("mult_neg",  3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 0);
      run_op("multu_big", 3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 64'd0, 64'h0000_0001_FFFF_FFFE, 0);
      run_op("mult_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 64'd0, 64'h4000_0000_0000_0000, 0);
      run_op("madd",      3'b011, 32'd3, 32'd4, 64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_000B, 0);
      run_op("msubu",     3'b100, 32'd2, 32'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      run_op("hold",      3'b001, 32'hFFFF_FFFD, 32'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFEB, 3);

      for (int i = 0; i < 30; i++) begin
         op  = 3'($urandom);
         a   = rnd_operand();
         b   = rnd_operand();
         acc = {$urandom, $urandom};
         run_op("rand", op, a, b, acc, model(op, a, b, acc), int'($urandom_range(0, 1)));
      end

      // Annul mid-operation, with start still asserted.
      prev = result_o;
      op_i = 3'b001; opdata1_i = $urandom; opdata2_i = 32'hFFFF_FFFF; acc_i = '0; start_i = 1'b1;
      @(posedge clk); #1;
      repeat (4) @(posedge clk);
      #1 annul_i = 1'b1;
      @(posedge clk); #1;
      check("annul_ready", 64'(ready_o), 64'd0);
      check("annul_busy", 64'(busy_o), 64'd0);
      check("annul_result", result_o, prev);
      annul_i = 1'b0; start_i = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("annul_noready", 64'(ready_o), 64'd0);
      check("annul_keep", result_o, prev);
      run_op("after_annul", 3'b000, 32'd6, 32'd7, 64'd0, 64'd42, 0);

      // Asynchronous reset in the middle of BUSY.
      op_i = 3'b000; opdata1_i = 32'd9; opdata2_i = 32'hFFFF_0000; start_i = 1'b1;
      @(posedge clk); #1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("midrst_result", result_o, 64'd0);
      check("midrst_ready", 64'(ready_o), 64'd0);
      check("midrst_busy", 64'(busy_o), 64'd0);
      start_i = 1'b0;
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      check("postrst_busy", 64'(busy_o), 64'd0);

      run_op("early_7x1", 3'b000, 32'd7, 32'd1, 64'd0, 64'd7, 0);
      run_op("mul_zero",  3'b001, 32'h1234_5678, 32'd0, 64'd0, 64'd0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mac_unit.md
# mac_unit

Parametrised iterative multiply/accumulate unit executing MULT, MULTU, MADD, MADDU, MSUB and MSUBU over several clock cycles. It sits beside the execute stage in the same way as the divider. Execute drives operands and a start level, holds its stall request while `ready_o` is low, and writes `result_o` to HI/LO. It replaces the single-cycle multiplier and the two-cycle MADD/MSUB stall sequence with one handshake and one configurable datapath.

## Interface
- `WIDTH`, 32: operand width in bits. The result is 2*WIDTH bits.
- `STEP`, 2: multiplier bits consumed per cycle. Must be 1, 2 or 4 and must divide WIDTH.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low (0 = reset).
- `start_i`  in  1  start level, held high by execute until it sees `ready_o`.
- `annul_i`  in  1  cancel the operation in progress (flush or exception).
- `op_i`  in  3  operation select:
  - bit0: 1 = signed.
  - bits[2:1]: 00 = MULT, 01 = MADD, 10 = MSUB, 11 = treated as MULT.
- `opdata1_i`  in  WIDTH  multiplicand (rs).
- `opdata2_i`  in  WIDTH  multiplier (rt).
- `acc_i`  in  2*WIDTH  forwarded {HI,LO}, used by MADD/MSUB.
- `result_o`  out  2*WIDTH  final {HI,LO}.
- `ready_o`  out  1  result valid.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, BUSY, FIX, DONE. Reset state is IDLE.
- Reset values: `result_o` = 0, `ready_o` = 0, `busy_o` = 0, all internal registers = 0.
- IDLE, `start_i`=1 and `annul_i`=0 → BUSY.
  - Latch op, `acc_i`, and the absolute values of both operands. Absolute values apply only when signed; unsigned operands are latched as-is.
  - Latch sign = opdata1[W-1] ^ opdata2[W-1] when signed, else 0.
  - Clear the 2W-bit partial product and the step counter.
- BUSY, each cycle:
  - partial += (mcand × mplier[STEP-1:0]) << (count×STEP).
  - mplier >>= STEP; count++.
  - After N = WIDTH/STEP steps → FIX.
- FIX, one cycle:
  - p = sign ? −partial : partial.
  - MADD: p = acc + p.
  - MSUB: p = acc − p.
  - All arithmetic is modulo 2^(2W).
  - Register p into `result_o` and go to DONE.
- DONE: `ready_o`=1. Stay in DONE while `start_i`=1; go to IDLE in the cycle after `start_i` is sampled 0.
- `annul_i`=1 in any state → IDLE on the next edge.
  - `ready_o` goes low.
  - `result_o` holds its previous value.
  - A simultaneous start is ignored; annul wins.
- Inputs are ignored outside IDLE, so operand changes during BUSY have no effect.
- The most negative operand is handled: its magnitude 2^(W-1) is representable unsigned, so (−2^(W-1))² = 2^(2W-2) is exact.

## Timing
- The start is captured at edge 0, in IDLE.
- Steps run on edges 1..N; FIX is edge N+1.
- `ready_o` is high after edge N+1. For WIDTH=32, STEP=2 this is 17 cycles after capture.
- `result_o` is stable from `ready_o` rising until the next accepted start.
- `ready_o` falls the cycle after `start_i` is sampled low. The earliest next start is accepted one cycle after that, from IDLE.
- Asynchronous reset forces IDLE and the reset values immediately, mid-operation included.

## Configuration
- `MAC_EARLY_TERM_EN` defined:
  - After a BUSY step, if the remaining shifted multiplier is 0, go to FIX immediately.
  - Latency is therefore k+1 edges, where k is the number of steps needed for the multiplier's highest set bit.
  - Minimum latency is 2 edges, including when the multiplier is 0.
- Not defined: fixed latency of N+1 edges regardless of operand values.
- The result is identical in both builds.

## Test plan
All scenarios use WIDTH=32, STEP=2, without the macro unless noted.
- MULT 0xFFFFFFFF × 0x00000002 → `result_o` 0xFFFFFFFF_FFFFFFFE; `ready_o` high exactly 17 cycles after capture.
- MULTU 0xFFFFFFFF × 0x00000002 → 0x00000001_FFFFFFFE. MULT 0x80000000 × 0x80000000 → 0x40000000_00000000.
- MADD 3 × 4, `acc_i` 0x00000000_FFFFFFFF → 0x00000001_0000000B. MSUBU 2 × 3, `acc_i` 5 → 0xFFFFFFFF_FFFFFFFF.
- Hold `start_i` high for 3 cycles after ready → `ready_o` and `result_o` held, no restart. Drop `start_i` → IDLE the next cycle.
- `annul_i` pulsed at BUSY step 5 → IDLE next cycle, no `ready_o`, `result_o` unchanged. A new MULTU 6 × 7 then gives 42.
- `rst`=0 mid-BUSY → all outputs 0 at once. With `MAC_EARLY_TERM_EN`: MULTU 7 × 1 → 7, ready after edge 2.
